lmsm_sequencer: RTL and testbench

- Multi-cycle controller for the load-multiple (LM, opcode 4'b1100) and store-multiple (SM, opcode 4'b1101) instructions.
- Takes the decoded base register value, the 8-bit register select word and the LM/SM type.
- Walks the set bits one per memory transfer, driving the register-file index, the word address and the memory strobes.
- Sits between the decoder/register-read stage and the data memory port, and holds the pipeline (busy) until the sequence ends.

---
 rtl/lmsm_sequencer_if.sv | 23 ++
 rtl/lmsm_sequencer.sv | 166 ++++++++++++++++
 tb/tb_lmsm_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/lmsm_sequencer_if.sv
// rtl/lmsm_sequencer_if.sv - data memory port bundle between the LM/SM sequencer and memory
interface lmsm_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    output mem_ack
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// rtl/lmsm_sequencer.sv - LM/SM multi-cycle sequencer; base writeback enabled by LMSM_BASE_WB_EN
module lmsm_sequencer #(
  parameter int ADDR_W = 16,
  parameter int NREG   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_store,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [2:0]          reg_ra,
  input  logic [NREG-1:0]     reg_select_word,
  lmsm_sequencer_if.master    mem,
  output logic [2:0]          rf_addr,
  output logic                rf_we,
  output logic                wb_sel,
  output logic [ADDR_W-1:0]   wb_data,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = $clog2(NREG + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
`ifdef LMSM_BASE_WB_EN
    , S_WB = 2'd3
`endif
  } state_t;

  state_t           state;
  logic [NREG-1:0]  mask_q;
  logic [CNT_W-1:0] count_q;
  logic             is_store_q;
  logic [NREG-1:0]  mask_left;
  logic [2:0]       next_reg;
  logic [2:0]       first_sel;

  // Select word bit 7 is R0, so the lowest register is the highest set bit.
  function automatic logic [2:0] first_reg(input logic [NREG-1:0] m);
    first_reg = '0;
    for (int i = 0; i < NREG; i++) begin
      if (m[i]) first_reg = 3'(NREG - 1 - i);
    end
  endfunction

  function automatic logic [NREG-1:0] reg_bit(input logic [2:0] r);
    reg_bit = '0;
    for (int i = 0; i < NREG; i++) begin
      reg_bit[i] = (NREG - 1 - i == int'(r));
    end
  endfunction

  always_comb begin
    mask_left = mask_q & ~reg_bit(rf_addr);
    next_reg  = first_reg(mask_left);
    first_sel = first_reg(reg_select_word);
    rf_we     = (state == S_XFER) && mem.mem_ack && !is_store_q;
`ifdef LMSM_BASE_WB_EN
    if (state == S_WB) rf_we = 1'b1;
`endif
  end

`ifdef LMSM_BASE_WB_EN
  logic [ADDR_W-1:0] base_q;
  logic [2:0]        ra_q;
`else
  logic unused_wb;
  assign unused_wb = ^{reg_ra, count_q};
  assign wb_sel    = 1'b0;
  assign wb_data   = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      mask_q       <= '0;
      count_q      <= '0;
      is_store_q   <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_we   <= 1'b0;
      mem.mem_addr <= '0;
      rf_addr      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef LMSM_BASE_WB_EN
      base_q       <= '0;
      ra_q         <= '0;
      wb_sel       <= 1'b0;
      wb_data      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy       <= 1'b1;
            is_store_q <= is_store;
            count_q    <= '0;
`ifdef LMSM_BASE_WB_EN
            base_q     <= base_addr;
            ra_q       <= reg_ra;
`endif
            if (reg_select_word != '0) begin
              state        <= S_XFER;
              mask_q       <= reg_select_word;
              mem.mem_addr <= base_addr;
              rf_addr      <= first_sel;
              mem.mem_req  <= 1'b1;
              mem.mem_we   <= is_store;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_XFER: begin
          if (mem.mem_ack) begin
            mask_q       <= mask_left;
            count_q      <= count_q + 1'b1;
            mem.mem_addr <= mem.mem_addr + 1'b1;
            if (mask_left != '0) begin
              // Next request issued straight away: no bubble between transfers.
              rf_addr <= next_reg;
            end else begin
              mem.mem_req <= 1'b0;
              mem.mem_we  <= 1'b0;
`ifdef LMSM_BASE_WB_EN
              state   <= S_WB;
              wb_sel  <= 1'b1;
              rf_addr <= ra_q;
              wb_data <= base_q + ADDR_W'(count_q) + ADDR_W'(1);
`else
              state   <= S_DONE;
              done    <= 1'b1;
              rf_addr <= '0;
`endif
            end
          end
        end

`ifdef LMSM_BASE_WB_EN
        S_WB: begin
          state   <= S_DONE;
          done    <= 1'b1;
          wb_sel  <= 1'b0;
          wb_data <= '0;
          rf_addr <= '0;
        end
`endif

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb/tb_lmsm_sequencer.sv - self-checking bench for lmsm_sequencer (honours LMSM_BASE_WB_EN)
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [15:0] base_addr;
  logic [2:0]  reg_ra;
  logic [7:0]  reg_select_word;
  logic [2:0]  rf_addr;
  logic        rf_we;
  logic        wb_sel;
  logic [15:0] wb_data;
  logic        busy;
  logic        done;

  lmsm_sequencer_if #(.ADDR_W(16)) mem_bus ();

  lmsm_sequencer #(.ADDR_W(16), .NREG(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .is_store        (is_store),
    .base_addr       (base_addr),
    .reg_ra          (reg_ra),
    .reg_select_word (reg_select_word),
    .mem             (mem_bus),
    .rf_addr         (rf_addr),
    .rf_we           (rf_we),
    .wb_sel          (wb_sel),
    .wb_data         (wb_data),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [15:0] base;
    logic [7:0]  sel;
    int          dly;
    logic [2:0]  ra;
    bit          poke;
  } vec_t;

  typedef struct {
    logic [2:0]  r;
    logic [15:0] a;
  } xfer_t;

  xfer_t exp_q[$];
  vec_t  tbl[6];
  int    nvec = 0;
  int    nmis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_bus.mem_req), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rf_we"}, 32'(rf_we), 0);
  endtask

  task automatic run_seq(input vec_t v);
    int          n = 0;
    int          cyc;
    int          w = 0;
    int          lat;
    bit          fin = 0;
    bit          wb_seen = 0;
    logic [15:0] a;
    xfer_t       x;
    a = v.base;
    for (int r = 0; r < 8; r++) begin
      if (v.sel[7-r]) begin
        x.r = 3'(r);
        x.a = a;
        exp_q.push_back(x);
        a = a + 16'd1;
        n++;
      end
    end
    lat = n * (v.dly + 1) + 1;
`ifdef LMSM_BASE_WB_EN
    if (n != 0) lat++;
`endif
    start = 1'b1; is_store = v.st; base_addr = v.base;
    reg_select_word = v.sel; reg_ra = v.ra;
    @(negedge clk);
    start = 1'b0; base_addr = 16'h5a5a; reg_select_word = 8'h3c; reg_ra = 3'd0;
    cyc = 1;
    while (!fin && cyc < 300) begin
      if (v.poke) begin
        start = (cyc == 2);
        reg_select_word = 8'hff;
      end
      if (mem_bus.mem_req) begin
        chk("mem_we", 32'(mem_bus.mem_we), 32'(v.st));
        if (exp_q.size() == 0) begin
          chk("extra_xfer", 1, 0);
          fin = 1;
        end else begin
          chk("rf_addr", 32'(rf_addr), 32'(exp_q[0].r));
          chk("mem_addr", 32'(mem_bus.mem_addr), 32'(exp_q[0].a));
          if (w == v.dly) begin
            mem_bus.mem_ack = 1'b1;
            #1;
            chk("rf_we_ack", 32'(rf_we), 32'(!v.st));
            void'(exp_q.pop_front());
            w = 0;
          end else begin
            mem_bus.mem_ack = 1'b0;
            #1;
            chk("rf_we_wait", 32'(rf_we), 0);
            w++;
          end
        end
      end else begin
        mem_bus.mem_ack = 1'b0;
        #1;
`ifdef LMSM_BASE_WB_EN
        if (wb_sel) begin
          wb_seen = 1;
          chk("wb_rf_we", 32'(rf_we), 1);
          chk("wb_rf_addr", 32'(rf_addr), 32'(v.ra));
          chk("wb_data", 32'(wb_data), 32'(16'(v.base + 16'(n))));
        end else begin
          chk("rf_we_idle", 32'(rf_we), 0);
        end
`else
        chk("wb_sel_off", 32'(wb_sel), 0);
        chk("wb_data_off", 32'(wb_data), 0);
        chk("rf_we_idle", 32'(rf_we), 0);
`endif
        if (done) begin
          chk("latency", 32'(cyc), 32'(lat));
          chk("drained", 32'(exp_q.size()), 0);
`ifdef LMSM_BASE_WB_EN
          chk("wb_seen", 32'(wb_seen), 32'(n != 0));
`endif
          fin = 1;
        end
      end
      chk("busy", 32'(busy), 1);
      @(negedge clk);
      cyc++;
    end
    if (!fin) chk("timeout", 0, 1);
    start = 1'b0;
    mem_bus.mem_ack = 1'b0;
    #1;
    chk_quiet("after_done");
    exp_q.delete();
  endtask

  initial begin
    tbl[0] = '{1'b0, 16'h0040, 8'b1010_0001, 0, 3'd3, 1'b0};
    tbl[1] = '{1'b1, 16'h0100, 8'hff,        2, 3'd5, 1'b0};
    tbl[2] = '{1'b0, 16'h1234, 8'h00,        0, 3'd1, 1'b0};
    tbl[3] = '{1'b0, 16'hffff, 8'b0000_0011, 0, 3'd6, 1'b0};
    tbl[4] = '{1'b1, 16'h0800, 8'b0101_0100, 1, 3'd2, 1'b1};
    tbl[5] = '{1'b1, 16'h0007, 8'b1000_0000, 0, 3'd4, 1'b0};

    rst = 1'b1; start = 1'b0; is_store = 1'b0; base_addr = '0;
    reg_ra = '0; reg_select_word = '0; mem_bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    chk("reset_rf_addr", 32'(rf_addr), 0);
    chk("reset_mem_addr", 32'(mem_bus.mem_addr), 0);
    chk("reset_wb_sel", 32'(wb_sel), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_seq(tbl[i]);
      if (i == 2) begin
        mem_bus.mem_ack = 1'b1;
        repeat (2) begin
          @(negedge clk);
          chk_quiet("spurious_ack");
        end
        mem_bus.mem_ack = 1'b0;
      end
    end

    // Reset while the second of three LM transfers waits for its ack.
    start = 1'b1; is_store = 1'b0; base_addr = 16'h0200; reg_select_word = 8'b1110_0000;
    @(negedge clk);
    start = 1'b0;
    mem_bus.mem_ack = 1'b1;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    chk("rst_pre_rf_addr", 32'(rf_addr), 1);
    chk("rst_pre_mem_addr", 32'(mem_bus.mem_addr), 32'h0201);
    chk("rst_pre_req", 32'(mem_bus.mem_req), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_quiet("mid_rst");
    chk("mid_rst_mem_addr", 32'(mem_bus.mem_addr), 0);
    @(negedge clk);
    chk_quiet("post_rst");
    run_seq(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
